// File: rtl/phase_edge_generator.sv
// -----------------------------------------------------------------------------
// phase_edge_generator
//
// Transmit side of the quarter-phase timing path. One accepted command places a
// single pulse at a coarse-cycle plus quarter-phase offset. The offset uses the
// same 2-bit phase code that the 4-phase sampling receiver reports. Each clk
// cycle the block emits a registered 4-slot pattern. That pattern drives an
// external 4:1 serializer clocked at 4x clk.
//
// Absolute slot numbering starts at the first cycle after the accept edge
// (c = 0), with n = 4c + k. The pulse covers slots [S, E):
//   S = 4*D + P + 1
//   E = S + W
//
// Ports
//   clk        in   1            single clock, pattern updated on rising edge
//   rst        in   1            asynchronous, active-low reset
//   cmd_valid  in   1            command request
//   cmd_ready  out  1            command accept (transfer on valid & ready)
//   cmd_delay  in   DELAY_WIDTH  coarse delay D in clk cycles
//   cmd_phase  in   2            phase code P (00 = 0deg .. 11 = 270deg)
//   cmd_width  in   WIDTH_WIDTH  high time W in quarter-cycles
//   abort      in   1            cancel the command in progress
//   pattern    out  4            pattern[k] = line level during quarter slot k
//   busy       out  1            a command is held (ACTIVE or GUARD)
//   done       out  1            one-cycle pulse when the pulse is fully emitted
// -----------------------------------------------------------------------------
module phase_edge_generator #(
  parameter int DELAY_WIDTH  = 16,
  parameter int WIDTH_WIDTH  = 8,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DELAY_WIDTH-1:0] cmd_delay,
  input  logic [1:0]             cmd_phase,
  input  logic [WIDTH_WIDTH-1:0] cmd_width,
  input  logic                   abort,
  output logic [3:0]             pattern,
  output logic                   busy,
  output logic                   done
);

  // Slot arithmetic width. The two spare bits keep E plus the final cycle's
  // slot offsets from wrapping, even at the largest D, P and W.
  localparam int SW = (((DELAY_WIDTH + 2) > WIDTH_WIDTH) ? (DELAY_WIDTH + 2) : WIDTH_WIDTH) + 2;
  // Guard counter holds GUARD_CYCLES-1 down to 0.
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   cnt_r, cnt_s;       // coarse cycle index c while ACTIVE
  logic [SW-1:0]   start_r, start_s;   // latched S
  logic [SW-1:0]   end_r, end_s;       // latched E
  logic [GW-1:0]   guard_r, guard_s;
  logic [3:0]      pattern_r, pattern_s;
  logic            done_r, done_s;
  logic            cmd_ready_r;
  logic            busy_r;

  logic [SW-1:0]   acc_start_s;
  logic [SW-1:0]   acc_end_s;
  logic [SW-1:0]   cnt_inc_s;
  logic [SW-1:0]   next_base_s;

  // Level of each of the four slots of the cycle whose first slot is base.
  function automatic logic [3:0] slot_pattern(input logic [SW-1:0] base,
                                              input logic [SW-1:0] s,
                                              input logic [SW-1:0] e);
    logic [3:0]    p;
    logic [SW-1:0] n;
    p = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      n    = base + SW'(k);
      p[k] = (n >= s) && (n < e);
    end
    return p;
  endfunction

  // Pulse bounds for the command on the input bus (used only on accept).
  assign acc_start_s = (SW'(cmd_delay) << 2) + SW'(cmd_phase) + SW'(1);
  assign acc_end_s   = acc_start_s + SW'(cmd_width);

  // First slot of the cycle following the current ACTIVE cycle.
  assign cnt_inc_s   = cnt_r + SW'(1);
  assign next_base_s = cnt_inc_s << 2;

  // Next-state, next-pattern and done decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    start_s   = start_r;
    end_s     = end_r;
    guard_s   = guard_r;
    pattern_s = 4'b0000;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Cycle 0 is already computed at the accept edge, so the pattern
        // stays registered with no combinational path to the outputs.
        if (cmd_valid && cmd_ready_r) begin
          state_s   = ST_ACTIVE;
          cnt_s     = {SW{1'b0}};
          start_s   = acc_start_s;
          end_s     = acc_end_s;
          pattern_s = slot_pattern({SW{1'b0}}, acc_start_s, acc_end_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (abort) begin
          state_s = ST_GUARD;
          guard_s = GW'(GUARD_CYCLES - 1);
        end else if (next_base_s >= end_r) begin
          // The next cycle starts at or past E. It is the done cycle and also
          // the first guard cycle.
          state_s = ST_GUARD;
          done_s  = 1'b1;
          guard_s = GW'(GUARD_CYCLES - 1);
        end else begin
          cnt_s     = cnt_inc_s;
          pattern_s = slot_pattern(next_base_s, start_r, end_r);
        end
      end
      ST_GUARD: begin
        if (guard_r == {GW{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          guard_s = guard_r - GW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears the line at once, with no clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {SW{1'b0}};
      start_r     <= {SW{1'b0}};
      end_r       <= {SW{1'b0}};
      guard_r     <= {GW{1'b0}};
      pattern_r   <= 4'b0000;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      start_r     <= start_s;
      end_r       <= end_s;
      guard_r     <= guard_s;
      pattern_r   <= pattern_s;
      done_r      <= done_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign pattern   = pattern_r;
  assign done      = done_r;
  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;

endmodule
